// File: rtl/core_config_pkg.sv
// ---------------------------------------------------------------------------
// core_config_pkg
// Shared configuration for the core's data-memory path: widths, the memory
// map constants, the controller FSM state type, and a small byte-lane merge
// helper used wherever a byte-enabled store updates a word.
// ---------------------------------------------------------------------------
package core_config_pkg;

   localparam int          XLEN       = 32;
   localparam int          DMEM_DEPTH = 4096;
   localparam logic [31:0] DMEM_BASE  = 32'h1000_0000;
   localparam logic [31:0] MMIO_BASE  = 32'h2000_0000;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      HOLD
   } dmem_fsm_t;

   // Which source feeds mem_rdata while an access is being presented.
   typedef enum logic [1:0] {
      RSEL_NONE,
      RSEL_RAM,
      RSEL_MMIO
   } dmem_rsel_t;

   // Replace only the byte lanes selected by be; the other lanes keep old_word.
   function automatic logic [XLEN-1:0] byte_merge(
      input logic [XLEN-1:0]   old_word,
      input logic [XLEN-1:0]   new_word,
      input logic [XLEN/8-1:0] be
   );
      logic [XLEN-1:0] merged;
      merged = old_word;
      for (int i = 0; i < XLEN/8; i++) begin
         if (be[i]) begin
            merged[i*8 +: 8] = new_word[i*8 +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// ---------------------------------------------------------------------------
// dmem_if
// Request/response bundle between the load/store unit and dmem_ctrl.
//   mem_req/mem_addr/mem_we/mem_byteen/mem_wdata : requester -> controller
//   mem_rdata/mem_err                           : controller -> requester
// master modport is the requester side, slave modport the controller side.
// ---------------------------------------------------------------------------
interface dmem_if #(
   parameter int XLEN = 32
);

   logic              mem_req;
   logic [XLEN-1:0]   mem_addr;
   logic              mem_we;
   logic [XLEN/8-1:0] mem_byteen;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN-1:0]   mem_rdata;
   logic              mem_err;

   modport master (
      output mem_req,
      output mem_addr,
      output mem_we,
      output mem_byteen,
      output mem_wdata,
      input  mem_rdata,
      input  mem_err
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      input  mem_we,
      input  mem_byteen,
      input  mem_wdata,
      output mem_rdata,
      output mem_err
   );

endinterface

// File: rtl/dmem_ram.sv
// ---------------------------------------------------------------------------
// dmem_ram
// Single-port synchronous SRAM with per-byte write enables and a registered
// read port. Contents and the read register are not reset.
//   clk   : clock
//   we/be : write strobe and byte-lane enables
//   re    : read strobe; rdata updates only on a read, otherwise holds
//   addr  : word index
//   wdata : lane-aligned write data
//   rdata : registered read data
// ---------------------------------------------------------------------------
module dmem_ram #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4096
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic                     re,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [XLEN/8-1:0]        be,
   input  logic [XLEN-1:0]          wdata,
   output logic [XLEN-1:0]          rdata
);

   logic [XLEN-1:0] mem_q [DEPTH];
   logic [XLEN-1:0] rdata_q;

   // Byte-lane writes and the registered read share the one port. The read
   // register holds its value between reads so the controller can present it
   // across a held request without re-reading.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < XLEN/8; i++) begin
            if (be[i]) begin
               mem_q[addr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
      if (re) begin
         rdata_q <= mem_q[addr];
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller behind the load/store unit. Each request rising
// from IDLE performs exactly one word-aligned, byte-enabled access to the
// internal SRAM (or the optional MMIO window); read data and the error flag
// are valid one cycle after the request edge and held while mem_req stays
// high.
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset
//   bus      : dmem_if.slave request/response bundle
//   gpio_out : MMIO GPIO register (0 when the MMIO window is not built)
// Build option: define DMEM_MMIO_EN to add the GPIO (MMIO_BASE+0, R/W) and
// CYCLE (MMIO_BASE+4, read-only free-running counter) registers.
// ---------------------------------------------------------------------------
module dmem_ctrl
   import core_config_pkg::*;
#(
   parameter int              XLEN        = core_config_pkg::XLEN,
   parameter int              DEPTH_WORDS = core_config_pkg::DMEM_DEPTH,
   parameter logic [XLEN-1:0] BASE_ADDR   = core_config_pkg::DMEM_BASE,
   parameter logic [XLEN-1:0] MMIO_BASE   = core_config_pkg::MMIO_BASE
) (
   input  logic            clk,
   input  logic            rst_n,
   dmem_if.slave           bus,
   output logic [XLEN-1:0] gpio_out
);

   localparam int              AW        = $clog2(DEPTH_WORDS);
   localparam logic [XLEN-1:0] RAM_BYTES = XLEN'(4 * DEPTH_WORDS);

   dmem_fsm_t       state_q, state_d;
   dmem_rsel_t      rsel_q, rsel_d;
   logic            err_q, err_d;

   logic [XLEN-1:0] addr_off;
   logic            in_ram;
   logic            mmio_hit;
   logic            mmio_ro_hit;
   logic            access_err;
   logic            start;
   logic            ram_we;
   logic            ram_re;
   logic [XLEN-1:0] ram_rdata;

`ifdef DMEM_MMIO_EN
   logic            is_gpio;
   logic            is_cycle;
   logic [XLEN-1:0] gpio_q, gpio_d;
   logic [XLEN-1:0] cycle_q, cycle_d;
   logic [XLEN-1:0] mmio_rdata_q, mmio_rdata_d;
`endif

   // Address decode. The range test compares the raw address against the base
   // first, so an address below the base cannot wrap into the RAM window via
   // the subtraction. Misaligned addresses err regardless of target, so the
   // MMIO registers only need exact-match decode.
   always_comb begin
      addr_off = bus.mem_addr - BASE_ADDR;
      in_ram   = (bus.mem_addr >= BASE_ADDR) && (addr_off < RAM_BYTES);
`ifdef DMEM_MMIO_EN
      is_gpio     = (bus.mem_addr == MMIO_BASE);
      is_cycle    = (bus.mem_addr == MMIO_BASE + XLEN'(4));
      mmio_hit    = is_gpio || is_cycle;
      mmio_ro_hit = is_cycle;
`else
      mmio_hit    = 1'b0;
      mmio_ro_hit = 1'b0;
`endif
      access_err = (bus.mem_byteen == '0)
                || (bus.mem_addr[1:0] != 2'b00)
                || !(in_ram || mmio_hit)
                || (bus.mem_we && mmio_ro_hit);
   end

`ifndef DMEM_MMIO_EN
   logic unused_mmio_base;
   assign unused_mmio_base = ^MMIO_BASE;
`endif

   // Side effects happen only on the edge a request is accepted from IDLE,
   // which is what keeps a held request from repeating its store.
   assign start  = (state_q == IDLE) && bus.mem_req;
   assign ram_we = start &&  bus.mem_we && !access_err && in_ram;
   assign ram_re = start && !bus.mem_we && !access_err && in_ram;

   dmem_ram #(
      .XLEN  (XLEN),
      .DEPTH (DEPTH_WORDS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (addr_off[AW+1:2]),
      .be    (bus.mem_byteen),
      .wdata (bus.mem_wdata),
      .rdata (ram_rdata)
   );

   // Next-state logic. The error flag and the read-data source are latched on
   // the accept edge and cleared whenever the FSM drops back to IDLE, so the
   // outputs read zero in IDLE and hold steady through ACCESS/HOLD even if the
   // requester changes address, data or direction meanwhile.
   always_comb begin
      state_d = state_q;
      rsel_d  = rsel_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (bus.mem_req) begin
               state_d = ACCESS;
               err_d   = access_err;
               if (access_err || bus.mem_we) begin
                  rsel_d = RSEL_NONE;
               end else if (in_ram) begin
                  rsel_d = RSEL_RAM;
               end else begin
                  rsel_d = RSEL_MMIO;
               end
            end
         end
         ACCESS: begin
            if (bus.mem_req) begin
               state_d = HOLD;
            end else begin
               state_d = IDLE;
               err_d   = 1'b0;
               rsel_d  = RSEL_NONE;
            end
         end
         HOLD: begin
            if (!bus.mem_req) begin
               state_d = IDLE;
               err_d   = 1'b0;
               rsel_d  = RSEL_NONE;
            end
         end
         default: begin
            state_d = IDLE;
            err_d   = 1'b0;
            rsel_d  = RSEL_NONE;
         end
      endcase
   end

   // FSM and response registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         rsel_q  <= RSEL_NONE;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rsel_q  <= rsel_d;
         err_q   <= err_d;
      end
   end

`ifdef DMEM_MMIO_EN
   // MMIO registers. CYCLE free-runs; a load captures its value as seen on the
   // request edge, i.e. before that edge's increment.
   always_comb begin
      gpio_d       = gpio_q;
      cycle_d      = cycle_q + XLEN'(1);
      mmio_rdata_d = mmio_rdata_q;
      if (start && !access_err && is_gpio && bus.mem_we) begin
         gpio_d = byte_merge(gpio_q, bus.mem_wdata, bus.mem_byteen);
      end
      if (start && !access_err && mmio_hit && !bus.mem_we) begin
         mmio_rdata_d = is_gpio ? gpio_q : cycle_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gpio_q       <= '0;
         cycle_q      <= '0;
         mmio_rdata_q <= '0;
      end else begin
         gpio_q       <= gpio_d;
         cycle_q      <= cycle_d;
         mmio_rdata_q <= mmio_rdata_d;
      end
   end

   assign gpio_out = gpio_q;
`else
   assign gpio_out = '0;
`endif

   // Response mux: only a successful load exposes data.
   always_comb begin
      unique case (rsel_q)
         RSEL_RAM:  bus.mem_rdata = ram_rdata;
`ifdef DMEM_MMIO_EN
         RSEL_MMIO: bus.mem_rdata = mmio_rdata_q;
`endif
         default:   bus.mem_rdata = '0;
      endcase
   end

   assign bus.mem_err = err_q;

endmodule
